// File: rtl/div_if.sv
// Divide request/result bundle between the EX stage and the multi-cycle divider.
interface div_if #(parameter int WIDTH = 32);
  logic             start;
  logic             is_signed;
  logic             annul;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             div_stall;
  logic             div_done;
  logic [WIDTH-1:0] quot;
  logic [WIDTH-1:0] rem;

  modport master (output start, is_signed, annul, a, b,
                  input  div_stall, div_done, quot, rem);
  modport slave  (input  start, is_signed, annul, a, b,
                  output div_stall, div_done, quot, rem);
endinterface

// File: rtl/div_unit.sv
// Radix-2 restoring divider (div/divu) feeding the HI/LO write path.
// Optional `DIV_EARLY_TERM_EN: finish in one cycle when |b| > |a|.
module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvs, q_w, p_rem;
  logic             sign_q, sign_r;
  logic [WIDTH-1:0] quot_q, rem_q;
  logic             done_q;

  function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
    return (~x) + WIDTH'(1);
  endfunction

  logic             a_neg, b_neg, accept, early, ge, last;
  logic [WIDTH-1:0] abs_a, abs_b, diff, nxt_rem, nxt_q;
  logic [WIDTH:0]   sh;

  assign a_neg  = bus.is_signed & bus.a[WIDTH-1];
  assign b_neg  = bus.is_signed & bus.b[WIDTH-1];
  assign abs_a  = a_neg ? neg(bus.a) : bus.a;
  assign abs_b  = b_neg ? neg(bus.b) : bus.b;
  assign accept = (state == IDLE) & bus.start & ~bus.annul;

`ifdef DIV_EARLY_TERM_EN
  assign early = (abs_b > abs_a);
`else
  assign early = 1'b0;
`endif

  // Shifted partial remainder needs one extra bit; when it is >= dvs the
  // true difference is < dvs, so the low WIDTH bits of the subtract suffice.
  assign sh      = {p_rem, q_w[WIDTH-1]};
  assign ge      = (sh >= {1'b0, dvs});
  assign diff    = sh[WIDTH-1:0] - dvs;
  assign nxt_rem = ge ? diff : sh[WIDTH-1:0];
  assign nxt_q   = {q_w[WIDTH-2:0], ge};
  assign last    = (cnt == CNT_W'(WIDTH-1));

  assign bus.div_stall = accept | (state == CALC);
  assign bus.div_done  = done_q;
  assign bus.quot      = quot_q;
  assign bus.rem       = rem_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      dvs    <= '0;
      q_w    <= '0;
      p_rem  <= '0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      quot_q <= '0;
      rem_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          dvs    <= abs_b;
          q_w    <= abs_a;
          p_rem  <= '0;
          cnt    <= '0;
          sign_q <= bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          sign_r <= a_neg;
          if (bus.b == '0) begin
            quot_q <= '1;
            rem_q  <= bus.a;
            done_q <= 1'b1;
            state  <= DONE;
          end else if (early) begin
            quot_q <= '0;
            rem_q  <= bus.a;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            state  <= CALC;
          end
        end
        CALC: if (bus.annul) begin
          state <= IDLE;
        end else begin
          p_rem <= nxt_rem;
          q_w   <= nxt_q;
          cnt   <= cnt + CNT_W'(1);
          if (last) begin
            quot_q <= sign_q ? neg(nxt_q) : nxt_q;
            rem_q  <= sign_r ? neg(nxt_rem) : nxt_rem;
            done_q <= 1'b1;
            state  <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// Randomized + directed bench for div_unit against an arithmetic reference.
module tb_div_unit;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  div_if #(.WIDTH(W)) bus();
  div_unit #(.WIDTH(W), .CNT_W(6)) u_dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] last_q, last_r;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Truncating division semantics of div/divu plus the divide-by-zero rule.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn,
                                  output logic [W-1:0] q, output logic [W-1:0] r, output int lat);
    longint sa, sb, qq, rr;
    if (b == '0) begin
      q = '1; r = a; lat = 1;
      return;
    end
    sa = sgn ? longint'($signed(a)) : longint'(a);
    sb = sgn ? longint'($signed(b)) : longint'(b);
    qq = sa / sb;
    rr = sa % sb;
    q  = W'(qq);
    r  = W'(rr);
    lat = W + 1;
`ifdef DIV_EARLY_TERM_EN
    if ((sb < 0 ? -sb : sb) > (sa < 0 ? -sa : sa)) lat = 1;
`endif
  endfunction

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic sgn, input string tag);
    logic [W-1:0] eq, er, gq, gr;
    int elat, cyc, stalls;
    bit done;
    ref_div(a, b, sgn, eq, er, elat);
    bus.start = 1'b1; bus.a = a; bus.b = b; bus.is_signed = sgn; bus.annul = 1'b0;
    cyc = 0; stalls = 0; done = 0; gq = '0; gr = '0;
    while (!done && cyc < 100) begin
      #1 if (bus.div_stall) stalls++;
      @(posedge clk); #1;
      cyc++;
      if (bus.div_done) begin
        done = 1; gq = bus.quot; gr = bus.rem;
      end
    end
    if (!done) begin
      chk({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      chk({tag, "_q"}, gq, eq);
      chk({tag, "_r"}, gr, er);
      chk({tag, "_lat"}, W'(cyc), W'(elat));
      chk({tag, "_stall"}, W'(stalls), W'(elat));
      chk({tag, "_stall_done"}, W'(bus.div_stall), 32'd0);
    end
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_done_1cyc"}, W'(bus.div_done), 32'd0);
    chk({tag, "_hold_q"}, bus.quot, eq);
    last_q = eq; last_r = er;
  endtask

  initial begin
    int done_cnt;
    logic [W-1:0] ra, rb;
    rst = 1'b1;
    bus.start = 1'b0; bus.is_signed = 1'b0; bus.annul = 1'b0; bus.a = '0; bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_quot", bus.quot, 32'd0);
    chk("rst_rem", bus.rem, 32'd0);
    chk("rst_done", W'(bus.div_done), 32'd0);
    chk("rst_stall", W'(bus.div_stall), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
    run_div(32'hFFFFFFF9, 32'd2, 1'b1, "div_m7_2");
    run_div(32'd7, 32'hFFFFFFFE, 1'b1, "div_7_m2");
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, "div_ovf");
    run_div(32'd5, 32'd0, 1'b0, "divu_by0");
    run_div(32'hFFFFFFF9, 32'd0, 1'b1, "div_by0");
    run_div(32'd3, 32'd10, 1'b0, "divu_3_10");
    run_div(32'hFFFFFFFF, 32'd1, 1'b0, "divu_max_1");
    run_div(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, "divu_max_max");

    // annul in the 10th CALC cycle
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7; bus.is_signed = 1'b0;
    @(posedge clk); #1;
    repeat (9) begin @(posedge clk); #1; end
    bus.annul = 1'b1; bus.start = 1'b0;
    #1 chk("annul_stall_calc", W'(bus.div_stall), 32'd1);
    @(posedge clk); #1;
    bus.annul = 1'b0;
    chk("annul_stall_next", W'(bus.div_stall), 32'd0);
    done_cnt = 0;
    repeat (40) begin
      if (bus.div_done) done_cnt++;
      @(posedge clk); #1;
    end
    chk("annul_no_done", W'(done_cnt), 32'd0);
    chk("annul_quot_kept", bus.quot, last_q);
    chk("annul_rem_kept", bus.rem, last_r);
    run_div(32'd9, 32'd3, 1'b0, "post_annul_9_3");

    // start with annul in IDLE must not be accepted
    bus.start = 1'b1; bus.annul = 1'b1; bus.a = 32'd50; bus.b = 32'd5;
    #1 chk("annul_idle_stall", W'(bus.div_stall), 32'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.annul = 1'b0;
    chk("annul_idle_noaccept", W'(bus.div_stall), 32'd0);
    @(posedge clk); #1;

    // reset in the 20th CALC cycle, start held through it
    bus.start = 1'b1; bus.a = 32'd100; bus.b = 32'd7; bus.is_signed = 1'b0;
    @(posedge clk); #1;
    repeat (19) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_done", W'(bus.div_done), 32'd0);
    chk("midrst_quot", bus.quot, 32'd0);
    chk("midrst_rem", bus.rem, 32'd0);
    rst = 1'b0;
    run_div(32'd100, 32'd7, 1'b0, "post_rst_100_7");

    for (int i = 0; i < 30; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = $urandom_range(1, 20);
        1: rb = '0;
        2: begin ra = 32'h80000000; rb = $urandom_range(0, 1) ? 32'hFFFFFFFF : 32'd1; end
        3: ra = $urandom_range(0, 100);
        default: ;
      endcase
      run_div(ra, rb, 1'($urandom_range(0, 1)), $sformatf("rnd%0d", i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle radix-2 restoring divider for the EX stage.
- Consumes the decode-side divide indication (isDiv, signedness from the div/divu funct) and produces quotient/remainder for the HI/LO write path.
- Holds the pipeline via a stall output while it iterates; the result is written by the existing hilo_we path in the cycle div_done is high.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  divide request from EX (isDiv of the EX instruction); held high by the pipeline while stalled.
- is_signed  input  1  1 = div, 0 = divu.
- annul  input  1  flush/exception; cancels any in-flight divide.
- a  input  WIDTH  dividend (rs), sampled only on acceptance.
- b  input  WIDTH  divisor (rt), sampled only on acceptance.
- div_stall  output  1  pipeline hold request.
- div_done  output  1  one-cycle result-valid pulse.
- quot  output  WIDTH  quotient, destined for LO.
- rem  output  WIDTH  remainder, destined for HI.

Behaviour:
- States: IDLE, CALC, DONE. Reset (rst=1 at a clock edge) forces IDLE, counter=0, quot=0, rem=0, div_done=0. rst overrides every other input.
- Acceptance: in IDLE with start=1 and annul=0.
  - Latch |a| and |b| (two's-complement negate when is_signed and the MSB is set).
  - Latch sign_q = is_signed & (a[31]^b[31]) and sign_r = is_signed & a[31].
  - Clear the partial remainder; go to CALC with counter=0.
- Divide by zero: b=0 at acceptance goes directly to DONE with quot=32'hFFFFFFFF and rem=a (raw, unsigned view), regardless of is_signed.
- CALC: one restoring step per cycle.
  - Shift {rem,quot} left by 1 and trial-subtract the divisor. If no borrow, keep the difference and set quot LSB=1; else restore and set LSB=0.
  - Counter increments each step. After WIDTH steps (counter==WIDTH-1 at the edge) go to DONE.
  - Entering DONE applies the sign fix: negate quot if sign_q, negate rem if sign_r.
- DONE: div_done=1 for exactly one cycle; quot/rem valid. start is ignored here (same instruction still present); unconditionally return to IDLE. quot/rem hold their values until the next acceptance.
- div_stall (combinational) = (state==IDLE & start & ~annul) | (state==CALC). It is 0 in DONE so the pipeline advances in the same cycle as the result write.
- Latency: accept at edge N; div_done high during cycle N+33 (N+1 for divide by zero). Stall is high for 33 cycles (cycles N..N+32).
- Overflow: -2^31 / -1 signed gives quot=32'h80000000, rem=0; no trap.
- annul in CALC: next state IDLE, no div_done, quot/rem unchanged from the previous result. annul in DONE: div_done still pulses; squashing the write is the pipeline's responsibility. annul with start in IDLE: no acceptance.
- Back-to-back: a new start in the cycle after DONE (state IDLE) is accepted normally; there is no bubble beyond that.
- rst mid-CALC: IDLE next cycle, stall drops immediately after the edge.

Optional Feature:
- DIV_EARLY_TERM_EN.
- Defined: at acceptance, if |b| > |a| (and b != 0), go directly to DONE with quot=0 and rem=a (the original signed value, no further fixup). Latency is 1 cycle.
- Undefined: every nonzero divide takes the full WIDTH iterations.
- Divide-by-zero behaviour is identical in both builds.

Test Plan:
- divu a=100, b=7 -> div_stall high for 33 cycles; div_done pulse with quot=14, rem=2.
- div a=-7 (32'hFFFFFFF9), b=2 -> quot=32'hFFFFFFFD (-3), rem=32'hFFFFFFFF (-1); div a=7, b=-2 -> quot=-3, rem=1.
- div a=32'h80000000, b=32'hFFFFFFFF -> quot=32'h80000000, rem=0; divu a=5, b=0 -> done after 1 cycle, quot=32'hFFFFFFFF, rem=5.
- divu 100/7 with annul pulsed at cycle 10 of CALC -> no div_done, stall low next cycle; an immediately following divu 9/3 -> quot=3, rem=0 after 33 cycles.
- rst asserted at cycle 20 of CALC -> IDLE, div_done=0, quot=rem=0; start held through the reset -> re-accepted on the first cycle after rst drops.
- With DIV_EARLY_TERM_EN: divu 3/10 -> div_done the cycle after accept, quot=0, rem=3. Without it: same result after 33 cycles.
